fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Reads the 6-bit PC value, issues a synchronous read to instruction memory, and latches the returned word into an instruction register.
- Presents the instruction and its PC to decode over a valid/ready handshake.
- Emits the one-cycle pc_advance pulse whose rising edge steps the PC to the next instruction (0..41, wrapping).

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 16 +
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and state encoding, also used by the PC and decode blocks.
package fetch_stage_pkg;
  localparam int PC_W      = 6;
  localparam int INSTR_W   = 32;
  localparam int NUM_INSTR = 42;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ADV, SETTLE} fetch_state_t;

  function automatic logic in_range(input logic [PC_W-1:0] pc);
    return pc < PC_W'(NUM_INSTR);
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port plus the fetch->decode valid/ready channel.
interface fetch_stage_if;
  import fetch_stage_pkg::*;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output imem_addr, imem_rd_en, instr_out, instr_pc, instr_valid,
                  input  imem_rdata, instr_ready);
  modport slave  (input  imem_addr, imem_rd_en, instr_out, instr_pc, instr_valid,
                  output imem_rdata, instr_ready);
endinterface

// File: rtl/fetch_stage.sv
// Fetch FSM: reads imem at the current PC, holds the word for decode, then pulses pc_advance.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  output logic            pc_advance,
  fetch_stage_if.master   bus
);
  fetch_state_t state;
  logic         to_req;

  // Read strobe and address are registered on entry to REQ so they are high for exactly the REQ cycle.
  always_comb begin
    to_req = 1'b0;
    case (state)
      IDLE, SETTLE:   to_req = 1'b1;
      REQ, WAIT, HOLD: to_req = flush;
      default:        to_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc_advance      <= 1'b0;
      bus.imem_rd_en  <= 1'b0;
      bus.imem_addr   <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= NOP_WORD;
      bus.instr_pc    <= '0;
    end else begin
      pc_advance     <= 1'b0;
      bus.imem_rd_en <= 1'b0;
      case (state)
        IDLE:   state <= REQ;
        REQ: begin
          if (flush) state <= REQ;
          else begin
            bus.instr_pc <= pc_in;
            if (in_range(pc_in)) state <= WAIT;
            else begin
              bus.instr_out   <= NOP_WORD;
              bus.instr_valid <= 1'b1;
              state           <= HOLD;
            end
          end
        end
        WAIT: begin
          if (flush) state <= REQ;
          else begin
            bus.instr_out   <= bus.imem_rdata;
            bus.instr_valid <= 1'b1;
            state           <= HOLD;
          end
        end
        HOLD: begin
          // flush beats a simultaneous handshake: the word is refetched, not consumed
          if (flush) begin
            bus.instr_valid <= 1'b0;
            state           <= REQ;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            pc_advance      <= 1'b1;
            state           <= ADV;
          end
        end
        ADV:     state <= SETTLE;
        SETTLE:  state <= REQ;
        default: state <= IDLE;
      endcase
      if (to_req) begin
        bus.imem_rd_en <= in_range(pc_in);
        bus.imem_addr  <= pc_in;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a sync-read ROM and a wrapping PC model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            pc_advance;
  logic [PC_W-1:0] pc;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc),
    .flush      (flush),
    .pc_advance (pc_advance),
    .bus        (bus.master)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_rise = -1;
  bit   spacing_en = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC model: 0..42 then back to 0, stepped by pc_advance
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_advance) pc <= (pc == 6'd42) ? 6'd0 : pc + 6'd1;
  end

  // Synchronous-read ROM; out-of-range reads return a poison word
  always @(posedge clk) begin
    if (bus.imem_rd_en)
      bus.imem_rdata <= (bus.imem_addr < 6'd42) ? 32'hA000_0000 + 32'(bus.imem_addr) : 32'hBAD0_0000;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = (p < 6'd42) ? 32'hA000_0000 + 32'(p) : 32'h0000_0000;
    sb.push_back(e);
  endtask

  task automatic tick();
    logic acc, held;
    logic [INSTR_W-1:0] p_out;
    logic [PC_W-1:0] p_pc;
    exp_t e;
    acc   = rst_n && bus.instr_valid && bus.instr_ready && !flush;
    held  = rst_n && bus.instr_valid && !bus.instr_ready && !flush;
    p_out = bus.instr_out;
    p_pc  = bus.instr_pc;
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      if (sb.size() == 0) chk("unexpected_accept", {58'b0, p_pc}, 64'hFFFF);
      else begin
        e = sb.pop_front();
        chk("acc_pc", p_pc, e.pc);
        chk("acc_instr", p_out, e.instr);
      end
    end
    chk("adv_pulse", pc_advance, acc);
    if (held) begin
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_instr", bus.instr_out, p_out);
      chk("hold_pc", bus.instr_pc, p_pc);
    end
    if (bus.imem_rd_en) begin
      chk("rd_in_range", bus.imem_addr < 6'd42, 1);
      chk("rd_addr_pc", bus.imem_addr, pc);
    end
    if (bus.instr_valid && !prev_valid) begin
      if (spacing_en && last_rise >= 0) chk("valid_spacing", cyc - last_rise, 5);
      last_rise = cyc;
    end
    prev_valid = bus.instr_valid;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin tick(); n++; end
    if (sb.size() > 0) chk("sb_timeout", sb.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.instr_valid && n < budget) begin tick(); n++; end
    if (!bus.instr_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic reset_to(input logic [PC_W-1:0] p);
    rst_n = 1'b0; pc_load = 1'b1; pc_load_val = p;
    tick(); tick();
    pc_load = 1'b0; rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adv"}, pc_advance, 0);
    chk({tag, "_rd_en"}, bus.imem_rd_en, 0);
    chk({tag, "_addr"}, bus.imem_addr, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_instr"}, bus.instr_out, NOP_WORD);
    chk({tag, "_pc"}, bus.instr_pc, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; bus.instr_ready = 1'b1;
    pc_load = 1'b1; pc_load_val = '0;
    tick(); tick();
    chk_reset_vals("reset");
    pc_load = 1'b0;

    // Streaming from PC 0 with decode always ready
    for (int i = 0; i < 5; i++) push(6'(i));
    spacing_en = 1;
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.instr_valid && n < 20);
    chk("first_valid_lat", n, 3);
    chk("first_instr", bus.instr_out, 32'hA000_0000);
    chk("first_pc", bus.instr_pc, 0);
    run_until_empty(100);
    spacing_en = 0;

    // Backpressure at PC 5
    bus.instr_ready = 1'b0;
    push(6'd5);
    wait_valid(20);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_instr", bus.instr_out, 32'hA000_0005);
    end
    bus.instr_ready = 1'b1;
    run_until_empty(20);

    // Wrap 40 -> 41 -> 42 (NOP) -> 0 -> 1
    bus.instr_ready = 1'b0;
    reset_to(6'd40);
    push(6'd40); push(6'd41); push(6'd42); push(6'd0); push(6'd1);
    bus.instr_ready = 1'b1;
    run_until_empty(100);

    // Flush while waiting on the read of PC 10
    bus.instr_ready = 1'b0;
    reset_to(6'd10);
    bus.instr_ready = 1'b1;
    tick();
    chk("flush_first_rd", bus.imem_rd_en, 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_reread", bus.imem_rd_en, 1);
    chk("flush_addr", bus.imem_addr, 10);
    chk("flush_valid", bus.instr_valid, 0);
    push(6'd10);
    run_until_empty(20);
    bus.instr_ready = 1'b0;

    // Flush and handshake together in HOLD at PC 3
    reset_to(6'd3);
    wait_valid(20);
    bus.instr_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; bus.instr_ready = 1'b0;
    chk("fh_valid", bus.instr_valid, 0);
    chk("fh_pc_kept", pc, 3);
    push(6'd3);
    bus.instr_ready = 1'b1;
    run_until_empty(20);

    // Reset lands on the ADV cycle; fetch resumes at the advanced PC
    chk("adv_before_rst", pc_advance, 1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_adv");
    rst_n = 1'b1;
    push(6'd4);
    run_until_empty(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
